disp_share_arb: RTL and testbench
=================================

# disp_share_arb

Arbiter and scan controller sharing the board's 3-digit multiplexed seven-segment display between two requesters, e.g. the debounced press counter and the lock state machine. It grants the display with a minimum hold time and round-robin fairness, latches the owner's 12-bit value and drives the active-low anode and cathode lines.

## Interface
- SCAN_DIV, 32768: clk cycles per digit slot; legal range 2..65535.
- HOLD_CYCLES, 50_000_000: minimum cycles a grant is held before it may be released or preempted; legal range 1..2^32-1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- req  in  2  request per requester; level, held while display wanted.
- val0  in  12  requester 0 value, 3 hex digits, [11:8] leftmost.
- val1  in  12  requester 1 value.
- gnt  out  2  registered one-hot grant; 2'b00 when idle.
- busy  out  1  registered; 1 when any grant active.
- anodes  out  3  active-low digit enables.
- cathodes  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE, GNT0, GNT1. Round-robin pointer `last` (0 or 1) records last-served requester.
- IDLE: if exactly one req bit is set, grant it. If both are set, grant the requester that is not `last`. Otherwise stay.
- On entry to GNTx: hold counter cleared, `last`<=x.
- GNTx, hold counter < HOLD_CYCLES-1: increment and stay; req[x] drop is ignored.
- GNTx, hold expired:
  - if req[other] is set, go to GNTother (preemption);
  - else if req[x] is set, stay and saturate the counter;
  - else go to IDLE.
- Display register disp_val (12b): loads val of the granted requester every cycle while granted. It holds its last value through IDLE, but cathodes are blanked in IDLE.
- Scan counter: counts 0..SCAN_DIV-1 and wraps. tick when count==SCAN_DIV-1.
- Anode rotation: on tick, anodes <= {anodes[0],anodes[2:1]}, giving 110→011→101→110. Scan runs regardless of grant state.
- Digit select: 011→disp_val[11:8], 101→[7:4], 110→[3:0], any other value→0.
- Segment codes (hex→cathodes[6:0] with dp=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
- IDLE: cathodes=8'hFF.

## Timing
- Reset values (reset low at a clk edge): state IDLE, gnt 0, busy 0, `last` 1 so requester 0 wins the first tie, hold count 0, scan count 0, anodes 3'b110, cathodes 8'hFF, disp_val 0.
- Reset has priority over every other event, including mid-grant and mid-scan.
- Grant latency: req sampled at edge N → gnt valid after edge N+1 (one cycle).
- Handover on preemption: gnt goes directly from 01 to 10; it never shows 11 and has no idle gap.
- Data latency: val change → disp_val after 1 clk → cathodes after 1 more clk (registered decode). Cathodes always match the current anodes one cycle after an anode change.
- A grant lasts at least HOLD_CYCLES cycles of gnt high.
- Simultaneous req rise in IDLE: resolved by `last` as above.
- req[x] drop and req[other] rise in the same cycle after hold expiry: go to GNTother.

## Configuration
- DISP_OWNER_DP_EN defined: the decimal point (cathodes[7]=0) lights on the rightmost digit (anodes 110) while gnt[1]=1, showing that requester 1 owns the display.
- Undefined: cathodes[7] is always 1.

## Structure
- Package disp_pkg holds:
  - the FSM state enum;
  - the anode reset constant 3'b110;
  - the 16-entry segment code constants, with a hex→segment function.
- One sub-module, disp_scan, owns the scan counter, anode rotation and registered cathode decode. Its inputs are disp_val, blank and dp.
- The arbiter FSM, hold counter and disp_val live in the top.

## Test plan
Run all scenarios with SCAN_DIV=4 and HOLD_CYCLES=8.
- Reset held, then released, no req → anodes=110, cathodes=FF, gnt=00; anodes read 011 after 4 clks and 101 after 8 clks.
- req=01, val0=12'h123 → gnt=01 one clk later; over one full scan, cathodes read A4 on 101, B0 on 110 and F9 on 011.
- req=11 set from IDLE after reset → gnt=01. After 8 granted cycles → gnt=10, with no 00 or 11 between.
- req=01, then req[0] dropped after 2 cycles → gnt stays 01 for 8 cycles, then 00, and cathodes go to FF.
- Reset pulled low during GNT1 → the next edge gives gnt=00, anodes=110, cathodes=FF.
- With DISP_OWNER_DP_EN defined: GNT1 with val1=0 → cathodes=40 on anode 110 and C0 on the other digits.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the shared seven-segment display arbiter.
// Holds the arbiter state encoding, anode reset pattern and hex-to-segment table.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_e;

  localparam logic [2:0] ANODE_RST = 3'b110;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off; entry 15 first, entry 0 last.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/disp_scan.sv
// Digit scan for a 3-digit multiplexed display: slot counter, anode rotation
// and registered cathode decode of the digit selected by the current anode.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] disp_val,
  input  logic        blank,
  input  logic        dp,
  output logic [2:0]  anodes,
  output logic [7:0]  cathodes
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] scan_cnt_r;
  logic        tick_s;
  logic [3:0]  digit_s;
  logic [7:0]  seg_s;

  assign tick_s = (scan_cnt_r == SCAN_LAST);

  // Slot counter, wraps at the end of each digit slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt_r <= 16'd0;
    end else if (tick_s) begin
      scan_cnt_r <= 16'd0;
    end else begin
      scan_cnt_r <= scan_cnt_r + 16'd1;
    end
  end

  // Anode rotation 110 -> 011 -> 101 -> 110.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anodes <= ANODE_RST;
    end else if (tick_s) begin
      anodes <= {anodes[0], anodes[2:1]};
    end else begin
      anodes <= anodes;
    end
  end

  // Pick the nibble belonging to the currently enabled digit.
  always_comb begin
    digit_s = 4'd0;
    case (anodes)
      3'b011:  digit_s = disp_val[11:8];
      3'b101:  digit_s = disp_val[7:4];
      3'b110:  digit_s = disp_val[3:0];
      default: digit_s = 4'd0;
    endcase
  end

  // Segment pattern with owner dot on the rightmost digit, or all dark when blanked.
  always_comb begin
    seg_s = hex_to_seg(digit_s);
    if (blank) begin
      seg_s = 8'hFF;
    end else begin
      seg_s[7] = ~(dp && (anodes == 3'b110));
    end
  end

  // Registered cathodes lag the anodes by exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cathodes <= 8'hFF;
    end else begin
      cathodes <= seg_s;
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Two-requester display arbiter with minimum hold and round-robin tie-break.
// Define DISP_OWNER_DP_EN to light the rightmost decimal point while requester 1 owns the display.
module disp_share_arb
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 32768,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [11:0] val0,
  input  logic [11:0] val1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [2:0]  anodes,
  output logic [7:0]  cathodes
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

  arb_state_e  state_r;
  arb_state_e  state_nxt_s;
  logic        last_r;
  logic [31:0] hold_r;
  logic        hold_done_s;
  logic [11:0] disp_val_r;
  logic [1:0]  gnt_nxt_s;
  logic        busy_nxt_s;
  logic        blank_s;
  logic        dp_s;
  logic        grant_entry_s;

  assign hold_done_s   = (hold_r >= HOLD_LAST);
  assign grant_entry_s = (state_nxt_s != state_r) && (state_nxt_s != ST_IDLE);

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next grant: ties go to whoever was not served last; the other side preempts after hold.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        case (req)
          2'b01:   state_nxt_s = ST_GNT0;
          2'b10:   state_nxt_s = ST_GNT1;
          2'b11:   state_nxt_s = last_r ? ST_GNT0 : ST_GNT1;
          default: state_nxt_s = ST_IDLE;
        endcase
      end
      ST_GNT0: begin
        if (!hold_done_s) begin
          state_nxt_s = ST_GNT0;
        end else if (req[1]) begin
          state_nxt_s = ST_GNT1;
        end else if (req[0]) begin
          state_nxt_s = ST_GNT0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!hold_done_s) begin
          state_nxt_s = ST_GNT1;
        end else if (req[0]) begin
          state_nxt_s = ST_GNT0;
        end else if (req[1]) begin
          state_nxt_s = ST_GNT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant and busy are decoded from the next state so they register in step with it.
  always_comb begin
    gnt_nxt_s = 2'b00;
    case (state_nxt_s)
      ST_GNT0: gnt_nxt_s = 2'b01;
      ST_GNT1: gnt_nxt_s = 2'b10;
      default: gnt_nxt_s = 2'b00;
    endcase
    busy_nxt_s = (gnt_nxt_s != 2'b00);
  end

  // Registered grant outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt  <= 2'b00;
      busy <= 1'b0;
    end else begin
      gnt  <= gnt_nxt_s;
      busy <= busy_nxt_s;
    end
  end

  // Hold counter restarts on every new grant and saturates once the hold has elapsed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_r <= 32'd0;
      last_r <= 1'b1;
    end else if (grant_entry_s) begin
      hold_r <= 32'd0;
      last_r <= (state_nxt_s == ST_GNT1);
    end else if ((state_r != ST_IDLE) && !hold_done_s) begin
      hold_r <= hold_r + 32'd1;
      last_r <= last_r;
    end else begin
      hold_r <= hold_r;
      last_r <= last_r;
    end
  end

  // Track the owner's value; keep the last one through idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_val_r <= 12'd0;
    end else begin
      case (state_r)
        ST_GNT0: disp_val_r <= val0;
        ST_GNT1: disp_val_r <= val1;
        default: disp_val_r <= disp_val_r;
      endcase
    end
  end

  assign blank_s = (state_r == ST_IDLE);

`ifdef DISP_OWNER_DP_EN
  assign dp_s = (state_r == ST_GNT1);
`else
  assign dp_s = 1'b0;
`endif

  disp_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .disp_val (disp_val_r),
    .blank    (blank_s),
    .dp       (dp_s),
    .anodes   (anodes),
    .cathodes (cathodes)
  );

endmodule

// File: tb/tb_disp_share_arb.sv
// Scoreboard bench for disp_share_arb: directed scenarios plus random traffic
// against a cycle-level behavioural model of owner, hold time and scan slot.
module tb_disp_share_arb;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 8;
`ifdef DISP_OWNER_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [2:0] AN_TAB [3] = '{3'b110, 3'b011, 3'b101};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [11:0] val0 = 12'h000;
  logic [11:0] val1 = 12'h000;
  logic [1:0]  gnt;
  logic        busy;
  logic [2:0]  anodes;
  logic [7:0]  cathodes;

  disp_share_arb #(
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .val0     (val0),
    .val1     (val1),
    .gnt      (gnt),
    .busy     (busy),
    .anodes   (anodes),
    .cathodes (cathodes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gnt;
    logic       busy;
    logic [2:0] an;
    logic [7:0] cat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: owner -1 = nobody; served = granted cycles shown so far.
  int          m_owner = -1;
  int          m_served = 0;
  int          m_last = 1;
  int          m_cnt = 0;
  int          m_aidx = 0;
  logic [11:0] m_disp = 12'h000;

  task automatic step(input logic r, input logic [1:0] rq, input logic [11:0] v0, input logic [11:0] v1);
    exp_t e;
    int   nxt;
    logic [3:0] nib;
    @(negedge clk);
    reset = r;
    req   = rq;
    val0  = v0;
    val1  = v1;
    if (!r) begin
      m_owner = -1; m_served = 0; m_last = 1; m_disp = 12'h000;
      m_cnt = 0; m_aidx = 0;
      e.cat = 8'hFF;
    end else begin
      // cathodes show what the display showed just before this edge
      if (m_owner < 0) begin
        e.cat = 8'hFF;
      end else begin
        case (m_aidx)
          0:       nib = m_disp[3:0];
          1:       nib = m_disp[11:8];
          default: nib = m_disp[7:4];
        endcase
        e.cat = SEG_TAB[nib];
        if (DP_EN && m_owner == 1 && m_aidx == 0) e.cat[7] = 1'b0;
      end
      if (m_owner == 0) m_disp = v0;
      else if (m_owner == 1) m_disp = v1;
      nxt = m_owner;
      if (m_owner < 0) begin
        if (rq == 2'b01) nxt = 0;
        else if (rq == 2'b10) nxt = 1;
        else if (rq == 2'b11) nxt = 1 - m_last;
      end else if (m_served >= HOLD) begin
        if (rq[1 - m_owner]) nxt = 1 - m_owner;
        else if (!rq[m_owner]) nxt = -1;
      end
      if (nxt >= 0 && nxt != m_owner) begin
        m_served = 1;
        m_last = nxt;
      end else if (nxt >= 0) begin
        m_served = (m_served >= HOLD) ? HOLD : m_served + 1;
      end
      m_owner = nxt;
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_aidx = (m_aidx + 1) % 3;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e.busy = (m_owner >= 0);
    e.an   = AN_TAB[m_aidx];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, want);
    end
  endtask

  // Monitor: compare each expectation just after the edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", {6'd0, gnt}, {6'd0, e.gnt});
        chk("busy", {7'd0, busy}, {7'd0, e.busy});
        chk("anodes", {5'd0, anodes}, {5'd0, e.an});
        chk("cathodes", cathodes, e.cat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r;
    logic [1:0]  rq;
    logic [11:0] v0;
    logic [11:0] v1;
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 12'h000, 12'h000);
    for (int i = 0; i < 12; i++) step(1'b1, 2'b00, 12'h000, 12'h000);
    for (int i = 0; i < 20; i++) step(1'b1, 2'b01, 12'h123, 12'hABC);
    for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 12'h123, 12'hABC);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 12'h000, 12'h000);
    for (int i = 0; i < 30; i++) step(1'b1, 2'b11, 12'h4D7, 12'hE58);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 12'h4D7, 12'hE58);
    for (int i = 0; i < 2; i++) step(1'b1, 2'b01, 12'h9F6, 12'h000);
    for (int i = 0; i < 14; i++) step(1'b1, 2'b00, 12'h9F6, 12'h000);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 12'h111, 12'hC0B);
    step(1'b0, 2'b10, 12'h111, 12'hC0B);
    for (int i = 0; i < 16; i++) step(1'b1, 2'b10, 12'h111, 12'h000);
    // hold expiry with req[x] drop and req[other] rise together
    for (int i = 0; i < 9; i++) step(1'b1, 2'b10, 12'h222, 12'h333);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b01, 12'h222, 12'h333);
    rq = 2'b00; v0 = 12'h000; v1 = 12'h000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(5) == 0) rq = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) v0 = 12'($urandom);
      if ($urandom_range(3) == 0) v1 = 12'($urandom);
      r = ($urandom_range(299) != 0);
      step(r, rq, v0, v1);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
